// File: rtl/lsu.sv
// Load/store unit for the memory stage.
// Accepts one load or store per transaction, issues it as a single registered
// request on the data bus, and returns an extended/merged load result.
// Address errors are flagged combinationally and never reach the bus.
//
// Optional feature: define LSU_UNALIGNED_EN to enable LWL/LWR/SWL/SWR
// (ops 9-12). When undefined those encodings behave like reserved ops.
//
// state | meaning
// IDLE  | waiting for a legal, aligned, unflushed request
// BUSY  | bus request outstanding, waiting for bus_ack_i
// DONE  | load result presented for one cycle; always returns to IDLE

module lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  input  logic [3:0]  mem_op_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] rt_data_i,
  input  logic        flush_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        stall_o,
  output logic        result_valid_o,
  output logic [31:0] result_o,
  output logic        exc_o,
  output logic        exc_store_o,
  output logic [31:0] badvaddr_o
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;
`ifdef LSU_UNALIGNED_EN
  localparam logic [3:0] OP_LWL = 4'd9;
  localparam logic [3:0] OP_LWR = 4'd10;
  localparam logic [3:0] OP_SWL = 4'd11;
  localparam logic [3:0] OP_SWR = 4'd12;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_bus_req;
  logic        r_bus_we;
  logic [3:0]  r_bus_be;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic [31:0] r_result;
  logic        r_load;
  logic        r_killed;
  logic [3:0]  r_op;
  logic [1:0]  r_lane;
`ifdef LSU_UNALIGNED_EN
  logic [31:0] r_rt;
`endif

  logic        w_legal;
  logic        w_is_load;
  logic        w_we;
  logic        w_misaligned;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [1:0]  w_n;
  logic        w_accept_cond;
  logic        w_accept;
  logic        w_stall;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic        w_result_valid;

  assign w_n = mem_addr_i[1:0];

  // Decode the requested op into legality, alignment, byte enables and store lanes.
  always_comb begin
    w_legal      = 1'b0;
    w_is_load    = 1'b0;
    w_we         = 1'b0;
    w_misaligned = 1'b0;
    w_be         = 4'b0000;
    w_wdata      = 32'h0;
    case (mem_op_i)
      OP_LB, OP_LBU: begin
        w_legal   = 1'b1;
        w_is_load = 1'b1;
        w_be      = 4'b0001 << w_n;
      end
      OP_LH, OP_LHU: begin
        w_legal      = 1'b1;
        w_is_load    = 1'b1;
        w_misaligned = w_n[0];
        w_be         = w_n[1] ? 4'b1100 : 4'b0011;
      end
      OP_LW: begin
        w_legal      = 1'b1;
        w_is_load    = 1'b1;
        w_misaligned = (w_n != 2'b00);
        w_be         = 4'b1111;
      end
      OP_SB: begin
        w_legal = 1'b1;
        w_we    = 1'b1;
        w_be    = 4'b0001 << w_n;
        w_wdata = {4{rt_data_i[7:0]}};
      end
      OP_SH: begin
        w_legal      = 1'b1;
        w_we         = 1'b1;
        w_misaligned = w_n[0];
        w_be         = w_n[1] ? 4'b1100 : 4'b0011;
        w_wdata      = {2{rt_data_i[15:0]}};
      end
      OP_SW: begin
        w_legal      = 1'b1;
        w_we         = 1'b1;
        w_misaligned = (w_n != 2'b00);
        w_be         = 4'b1111;
        w_wdata      = rt_data_i;
      end
`ifdef LSU_UNALIGNED_EN
      // Partial-word ops read or write only the bytes that take part in the merge.
      OP_LWL: begin
        w_legal   = 1'b1;
        w_is_load = 1'b1;
        w_be      = 4'b1111 >> (~w_n);
      end
      OP_LWR: begin
        w_legal   = 1'b1;
        w_is_load = 1'b1;
        w_be      = 4'b1111 << w_n;
      end
      OP_SWL: begin
        w_legal = 1'b1;
        w_we    = 1'b1;
        w_be    = 4'b1111 >> (~w_n);
        w_wdata = rt_data_i >> {~w_n, 3'b000};
      end
      OP_SWR: begin
        w_legal = 1'b1;
        w_we    = 1'b1;
        w_be    = 4'b1111 << w_n;
        w_wdata = rt_data_i << {w_n, 3'b000};
      end
`endif
      default: begin
        w_legal = 1'b0;
      end
    endcase
  end

  assign w_accept_cond = req_valid_i & w_legal & ~w_misaligned & ~flush_i;

  // Extract and extend the load data from the lanes latched at accept time.
  always_comb begin
    w_byte = bus_rdata_i[7:0];
    case (r_lane)
      2'd1:    w_byte = bus_rdata_i[15:8];
      2'd2:    w_byte = bus_rdata_i[23:16];
      2'd3:    w_byte = bus_rdata_i[31:24];
      default: w_byte = bus_rdata_i[7:0];
    endcase
    w_half      = r_lane[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
    w_load_data = bus_rdata_i;
    case (r_op)
      OP_LB:  w_load_data = {{24{w_byte[7]}}, w_byte};
      OP_LBU: w_load_data = {24'h0, w_byte};
      OP_LH:  w_load_data = {{16{w_half[15]}}, w_half};
      OP_LHU: w_load_data = {16'h0, w_half};
`ifdef LSU_UNALIGNED_EN
      OP_LWL: w_load_data = (bus_rdata_i << {~r_lane, 3'b000})
                          | (r_rt & (32'h00FF_FFFF >> {r_lane, 3'b000}));
      OP_LWR: w_load_data = (bus_rdata_i >> {r_lane, 3'b000})
                          | (r_rt & ~(32'hFFFF_FFFF >> {r_lane, 3'b000}));
`endif
      default: w_load_data = bus_rdata_i;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_stall     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept_cond) begin
          w_state_nxt = S_BUSY;
          w_accept    = 1'b1;
          w_stall     = 1'b1;
        end
      end
      S_BUSY: begin
        w_stall = 1'b1;
        if (bus_ack_i) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Bus request registers and result capture; a flush in BUSY lets the bus
  // transfer finish but suppresses the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_be    <= 4'b0000;
      r_bus_addr  <= 32'h0;
      r_bus_wdata <= 32'h0;
      r_result    <= 32'h0;
      r_load      <= 1'b0;
      r_killed    <= 1'b0;
      r_op        <= 4'd0;
      r_lane      <= 2'd0;
`ifdef LSU_UNALIGNED_EN
      r_rt        <= 32'h0;
`endif
    end else if (w_accept) begin
      r_bus_req   <= 1'b1;
      r_bus_we    <= w_we;
      r_bus_be    <= w_be;
      r_bus_addr  <= {mem_addr_i[31:2], 2'b00};
      r_bus_wdata <= w_wdata;
      r_load      <= w_is_load;
      r_killed    <= 1'b0;
      r_op        <= mem_op_i;
      r_lane      <= w_n;
`ifdef LSU_UNALIGNED_EN
      r_rt        <= rt_data_i;
`endif
    end else if (r_state == S_BUSY) begin
      if (flush_i) begin
        r_killed <= 1'b1;
      end
      if (bus_ack_i) begin
        r_bus_req <= 1'b0;
        if (r_load) begin
          r_result <= w_load_data;
        end
      end
    end
  end

  assign w_result_valid = (r_state == S_DONE) & r_load & ~r_killed;

  assign bus_req_o      = r_bus_req;
  assign bus_we_o       = r_bus_we;
  assign bus_be_o       = r_bus_be;
  assign bus_addr_o     = r_bus_addr;
  assign bus_wdata_o    = r_bus_wdata;
  assign stall_o        = w_stall & ~rst;
  assign result_valid_o = w_result_valid;
  assign result_o       = w_result_valid ? r_result : 32'h0;
  assign exc_o          = (r_state == S_IDLE) & req_valid_i & w_legal & w_misaligned & ~flush_i;
  assign exc_store_o    = exc_o & w_we;
  assign badvaddr_o     = exc_o ? mem_addr_i : 32'h0;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: a table of single-transaction vectors plus
// hand-written sequences for flush and reset during an outstanding request.
// Load results are pushed to a scoreboard queue when the request is driven
// and popped when the DUT raises result_valid_o.

module tb_lsu;

  logic        clk;
  logic        rst;
  logic        req_valid_i;
  logic [3:0]  mem_op_i;
  logic [31:0] mem_addr_i;
  logic [31:0] rt_data_i;
  logic        flush_i;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;
  logic        stall_o;
  logic        result_valid_o;
  logic [31:0] result_o;
  logic        exc_o;
  logic        exc_store_o;
  logic [31:0] badvaddr_o;

  int checks;
  int errors;
  logic [31:0] sb_q[$];

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] rt;
    logic [31:0] rdata;
    int          waits;
    bit          bus;
    bit          we;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          exc;
    bit          exc_store;
    bit          load;
    logic [31:0] result;
  } vec_t;

  vec_t vecs[$];

  lsu dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid_i),
    .mem_op_i       (mem_op_i),
    .mem_addr_i     (mem_addr_i),
    .rt_data_i      (rt_data_i),
    .flush_i        (flush_i),
    .bus_req_o      (bus_req_o),
    .bus_we_o       (bus_we_o),
    .bus_be_o       (bus_be_o),
    .bus_addr_o     (bus_addr_o),
    .bus_wdata_o    (bus_wdata_o),
    .bus_ack_i      (bus_ack_i),
    .bus_rdata_i    (bus_rdata_i),
    .stall_o        (stall_o),
    .result_valid_o (result_valid_o),
    .result_o       (result_o),
    .exc_o          (exc_o),
    .exc_store_o    (exc_store_o),
    .badvaddr_o     (badvaddr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] addr,
                              input logic [31:0] rt, input logic [31:0] rdata,
                              input int waits, input bit bus, input bit we,
                              input logic [3:0] be, input logic [31:0] wdata,
                              input bit exc, input bit exc_store,
                              input bit load, input logic [31:0] result);
    vec_t v;
    v.op = op; v.addr = addr; v.rt = rt; v.rdata = rdata; v.waits = waits;
    v.bus = bus; v.we = we; v.be = be; v.wdata = wdata; v.exc = exc;
    v.exc_store = exc_store; v.load = load; v.result = result;
    return v;
  endfunction

  // Compare the DONE-cycle result against the scoreboard.
  task automatic check_result(input bit exp_valid);
    logic [31:0] exp_res;
    chk("result_valid", {31'h0, result_valid_o}, {31'h0, exp_valid});
    if (result_valid_o) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got result %h expected no result", result_o);
      end else begin
        exp_res = sb_q.pop_front();
        chk("result", result_o, exp_res);
      end
    end else begin
      chk("result_zero", result_o, 32'h0);
      if (exp_valid && sb_q.size() > 0) begin
        exp_res = sb_q.pop_front();
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    int stall_cnt;
    logic [31:0] exp_addr;
    stall_cnt = 0;
    exp_addr  = {v.addr[31:2], 2'b00};
    @(negedge clk);
    req_valid_i = 1'b1;
    mem_op_i    = v.op;
    mem_addr_i  = v.addr;
    rt_data_i   = v.rt;
    flush_i     = 1'b0;
    bus_ack_i   = 1'b0;
    #1;
    chk("exc", {31'h0, exc_o}, {31'h0, v.exc});
    if (v.exc) begin
      chk("exc_store", {31'h0, exc_store_o}, {31'h0, v.exc_store});
      chk("badvaddr", badvaddr_o, v.addr);
    end else begin
      chk("badvaddr_zero", badvaddr_o, 32'h0);
    end
    if (!v.bus) begin
      chk("stall_nobus", {31'h0, stall_o}, 32'h0);
      @(negedge clk);
      chk("bus_req_nobus", {31'h0, bus_req_o}, 32'h0);
      chk("stall_nobus2", {31'h0, stall_o}, 32'h0);
      req_valid_i = 1'b0;
      mem_op_i    = 4'd0;
      return;
    end
    if (stall_o) stall_cnt++;
    if (v.load) sb_q.push_back(v.result);
    for (int w = 0; w <= v.waits; w++) begin
      @(negedge clk);
      chk("bus_req", {31'h0, bus_req_o}, 32'h1);
      chk("bus_we", {31'h0, bus_we_o}, {31'h0, v.we});
      chk("bus_be", {28'h0, bus_be_o}, {28'h0, v.be});
      chk("bus_addr", bus_addr_o, exp_addr);
      if (v.we) chk("bus_wdata", bus_wdata_o, v.wdata);
      chk("result_valid_busy", {31'h0, result_valid_o}, 32'h0);
      if (stall_o) stall_cnt++;
      if (w == v.waits) begin
        bus_ack_i   = 1'b1;
        bus_rdata_i = v.rdata;
      end
    end
    @(negedge clk);
    bus_ack_i   = 1'b0;
    bus_rdata_i = 32'h5A5A_5A5A;
    chk("bus_req_done", {31'h0, bus_req_o}, 32'h0);
    chk("stall_done", {31'h0, stall_o}, 32'h0);
    chk("stall_cycles", stall_cnt, v.waits + 2);
    check_result(v.load);
    req_valid_i = 1'b0;
    mem_op_i    = 4'd0;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    req_valid_i = 1'b0;
    mem_op_i    = 4'd0;
    mem_addr_i  = 32'h0;
    rt_data_i   = 32'h0;
    flush_i     = 1'b0;
    bus_ack_i   = 1'b0;
    bus_rdata_i = 32'h0;

    //        op     addr          rt            rdata        w  bus we be       wdata        exc st ld result
    vecs.push_back(mk(4'd1, 32'h0000_1003, 32'h0,         32'h8011_2233, 0, 1, 0, 4'b1000, 32'h0,         0, 0, 1, 32'hFFFF_FF80));
    vecs.push_back(mk(4'd7, 32'h0000_2002, 32'h0000_BEEF, 32'h0,         4, 1, 1, 4'b1100, 32'hBEEF_BEEF, 0, 0, 0, 32'h0));
    vecs.push_back(mk(4'd5, 32'h0000_3001, 32'h0,         32'h0,         0, 0, 0, 4'b0000, 32'h0,         1, 0, 0, 32'h0));
    vecs.push_back(mk(4'd2, 32'h0000_1001, 32'h0,         32'h8011_A233, 1, 1, 0, 4'b0010, 32'h0,         0, 0, 1, 32'h0000_00A2));
    vecs.push_back(mk(4'd3, 32'h0000_1002, 32'h0,         32'h8001_1234, 0, 1, 0, 4'b1100, 32'h0,         0, 0, 1, 32'hFFFF_8001));
    vecs.push_back(mk(4'd4, 32'h0000_1000, 32'h0,         32'h1234_F00D, 3, 1, 0, 4'b0011, 32'h0,         0, 0, 1, 32'h0000_F00D));
    vecs.push_back(mk(4'd5, 32'h0000_1004, 32'h0,         32'hDEAD_BEEF, 2, 1, 0, 4'b1111, 32'h0,         0, 0, 1, 32'hDEAD_BEEF));
    vecs.push_back(mk(4'd6, 32'h0000_2001, 32'h1234_56AB, 32'h0,         0, 1, 1, 4'b0010, 32'hABAB_ABAB, 0, 0, 0, 32'h0));
    vecs.push_back(mk(4'd8, 32'h0000_2008, 32'hCAFE_F00D, 32'h0,         1, 1, 1, 4'b1111, 32'hCAFE_F00D, 0, 0, 0, 32'h0));
    vecs.push_back(mk(4'd7, 32'h0000_2003, 32'h0,         32'h0,         0, 0, 0, 4'b0000, 32'h0,         1, 1, 0, 32'h0));
    vecs.push_back(mk(4'd8, 32'h0000_2006, 32'h0,         32'h0,         0, 0, 0, 4'b0000, 32'h0,         1, 1, 0, 32'h0));
    vecs.push_back(mk(4'd4, 32'h0000_1001, 32'h0,         32'h0,         0, 0, 0, 4'b0000, 32'h0,         1, 0, 0, 32'h0));
    vecs.push_back(mk(4'd0, 32'h0000_1000, 32'h0,         32'h0,         0, 0, 0, 4'b0000, 32'h0,         0, 0, 0, 32'h0));
    vecs.push_back(mk(4'd13, 32'h0000_1001, 32'h0,        32'h0,         0, 0, 0, 4'b0000, 32'h0,         0, 0, 0, 32'h0));
    vecs.push_back(mk(4'd15, 32'h0000_1000, 32'h0,        32'h0,         0, 0, 0, 4'b0000, 32'h0,         0, 0, 0, 32'h0));
    vecs.push_back(mk(4'd1, 32'h0000_1000, 32'h0,         32'h0000_007F, 0, 1, 0, 4'b0001, 32'h0,         0, 0, 1, 32'h0000_007F));
    vecs.push_back(mk(4'd1, 32'h0000_1002, 32'h0,         32'h00FE_0000, 1, 1, 0, 4'b0100, 32'h0,         0, 0, 1, 32'hFFFF_FFFE));
`ifdef LSU_UNALIGNED_EN
    vecs.push_back(mk(4'd9,  32'h0000_4001, 32'h1122_3344, 32'hAABB_CCDD, 1, 1, 0, 4'b0011, 32'h0,         0, 0, 1, 32'hCCDD_3344));
    vecs.push_back(mk(4'd9,  32'h0000_4003, 32'h1122_3344, 32'hAABB_CCDD, 0, 1, 0, 4'b1111, 32'h0,         0, 0, 1, 32'hAABB_CCDD));
    vecs.push_back(mk(4'd10, 32'h0000_4001, 32'h1122_3344, 32'hAABB_CCDD, 0, 1, 0, 4'b1110, 32'h0,         0, 0, 1, 32'h11AA_BBCC));
    vecs.push_back(mk(4'd11, 32'h0000_4001, 32'h1122_3344, 32'h0,         0, 1, 1, 4'b0011, 32'h0000_1122, 0, 0, 0, 32'h0));
    vecs.push_back(mk(4'd12, 32'h0000_4002, 32'h1122_3344, 32'h0,         2, 1, 1, 4'b1100, 32'h3344_0000, 0, 0, 0, 32'h0));
`else
    vecs.push_back(mk(4'd9,  32'h0000_4001, 32'h1122_3344, 32'h0,         0, 0, 0, 4'b0000, 32'h0,         0, 0, 0, 32'h0));
    vecs.push_back(mk(4'd10, 32'h0000_4001, 32'h1122_3344, 32'h0,         0, 0, 0, 4'b0000, 32'h0,         0, 0, 0, 32'h0));
    vecs.push_back(mk(4'd11, 32'h0000_4003, 32'h1122_3344, 32'h0,         0, 0, 0, 4'b0000, 32'h0,         0, 0, 0, 32'h0));
    vecs.push_back(mk(4'd12, 32'h0000_4002, 32'h1122_3344, 32'h0,         0, 0, 0, 4'b0000, 32'h0,         0, 0, 0, 32'h0));
`endif

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_bus_req", {31'h0, bus_req_o}, 32'h0);
    chk("rst_bus_we", {31'h0, bus_we_o}, 32'h0);
    chk("rst_bus_be", {28'h0, bus_be_o}, 32'h0);
    chk("rst_bus_addr", bus_addr_o, 32'h0);
    chk("rst_bus_wdata", bus_wdata_o, 32'h0);
    chk("rst_stall", {31'h0, stall_o}, 32'h0);
    chk("rst_result_valid", {31'h0, result_valid_o}, 32'h0);
    chk("rst_result", result_o, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i]);
    end

    // Flush in IDLE: neither an exception nor an accept.
    @(negedge clk);
    req_valid_i = 1'b1; mem_op_i = 4'd5; mem_addr_i = 32'h0000_3001; flush_i = 1'b1;
    #1;
    chk("flush_idle_exc", {31'h0, exc_o}, 32'h0);
    chk("flush_idle_stall", {31'h0, stall_o}, 32'h0);
    @(negedge clk);
    mem_addr_i = 32'h0000_3000;
    #1;
    chk("flush_idle_stall2", {31'h0, stall_o}, 32'h0);
    @(negedge clk);
    chk("flush_idle_bus_req", {31'h0, bus_req_o}, 32'h0);
    flush_i = 1'b0; req_valid_i = 1'b0;

    // Flush in BUSY: bus transfer completes, stall held to ack, no result.
    @(negedge clk);
    req_valid_i = 1'b1; mem_op_i = 4'd5; mem_addr_i = 32'h0000_3000;
    #1;
    chk("flushb_accept_stall", {31'h0, stall_o}, 32'h1);
    @(negedge clk);
    flush_i = 1'b1;
    #1;
    chk("flushb_busy1_stall", {31'h0, stall_o}, 32'h1);
    chk("flushb_busy1_req", {31'h0, bus_req_o}, 32'h1);
    @(negedge clk);
    chk("flushb_busy2_stall", {31'h0, stall_o}, 32'h1);
    chk("flushb_busy2_req", {31'h0, bus_req_o}, 32'h1);
    @(negedge clk);
    chk("flushb_busy3_stall", {31'h0, stall_o}, 32'h1);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h1234_5678;
    @(negedge clk);
    bus_ack_i = 1'b0; flush_i = 1'b0; req_valid_i = 1'b0;
    chk("flushb_done_valid", {31'h0, result_valid_o}, 32'h0);
    chk("flushb_done_result", result_o, 32'h0);
    chk("flushb_done_stall", {31'h0, stall_o}, 32'h0);
    chk("flushb_done_req", {31'h0, bus_req_o}, 32'h0);
    @(negedge clk);
    chk("flushb_idle_valid", {31'h0, result_valid_o}, 32'h0);

    // Reset in BUSY: request dropped, later ack ignored.
    @(negedge clk);
    req_valid_i = 1'b1; mem_op_i = 4'd5; mem_addr_i = 32'h0000_3004;
    @(negedge clk);
    chk("rstb_busy_req", {31'h0, bus_req_o}, 32'h1);
    rst = 1'b1;
    #1;
    chk("rstb_stall_in_rst", {31'h0, stall_o}, 32'h0);
    @(negedge clk);
    rst = 1'b0; req_valid_i = 1'b0;
    chk("rstb_req_dropped", {31'h0, bus_req_o}, 32'h0);
    chk("rstb_stall_after", {31'h0, stall_o}, 32'h0);
    bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk);
    bus_ack_i = 1'b0;
    chk("rstb_ack_ignored_valid", {31'h0, result_valid_o}, 32'h0);
    chk("rstb_ack_ignored_req", {31'h0, bus_req_o}, 32'h0);
    chk("rstb_ack_ignored_stall", {31'h0, stall_o}, 32'h0);
    @(negedge clk);
    chk("rstb_idle_valid", {31'h0, result_valid_o}, 32'h0);

    // Normal load after reset recovery.
    run_vec(mk(4'd5, 32'h0000_5000, 32'h0, 32'h0BAD_F00D, 1, 1, 0, 4'b1111, 32'h0, 0, 0, 1, 32'h0BAD_F00D));

    chk("sb_empty", sb_q.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
